// File: rtl/matrix_scanner.sv
// 5x5 switch matrix scanner: walks a one-hot row drive, samples synchronized
// column lines per row and commits a debounced frame on row0..row4.
module matrix_scanner #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       PIXEL_CLK,
    input  logic       reset,
    input  logic [4:0] col_in,
    output logic [4:0] row_sel,
    output logic [4:0] row0,
    output logic [4:0] row1,
    output logic [4:0] row2,
    output logic [4:0] row3,
    output logic [4:0] row4,
    output logic       frame_valid
);

    localparam int DW = $clog2(SETTLE_CYCLES);
    localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

    logic [4:0]    col_meta_q, col_sync_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    row_q, row_d;
    logic [4:0]    row_sel_q, row_sel_d;
    logic [24:0]   raw_q, raw_d;
    logic [24:0]   prev_q, prev_d;
    logic [SW-1:0] stable_q, stable_d;
    logic          eval_q, eval_d;
    logic [24:0]   frame_q, frame_d;
    logic          valid_q, valid_d;

    // Row walk: dwell counting, per-row sampling into the raw frame, end-of-scan flag.
    always_comb begin
        dwell_d = dwell_q + DW'(1);
        row_d   = row_q;
        raw_d   = raw_q;
        eval_d  = 1'b0;
        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            case (row_q)
                3'd0:    raw_d[4:0]   = col_sync_q;
                3'd1:    raw_d[9:5]   = col_sync_q;
                3'd2:    raw_d[14:10] = col_sync_q;
                3'd3:    raw_d[19:15] = col_sync_q;
                3'd4:    raw_d[24:20] = col_sync_q;
                default: raw_d        = raw_q;
            endcase
            if (row_q == 3'd4) begin
                row_d  = 3'd0;
                eval_d = 1'b1;
            end else begin
                row_d  = row_q + 3'd1;
            end
        end else begin
            row_d = row_q;
        end
    end

    // One-hot drive for the row that will be active after this edge.
    always_comb begin
        case (row_d)
            3'd0:    row_sel_d = 5'b00001;
            3'd1:    row_sel_d = 5'b00010;
            3'd2:    row_sel_d = 5'b00100;
            3'd3:    row_sel_d = 5'b01000;
            3'd4:    row_sel_d = 5'b10000;
            default: row_sel_d = 5'b00001;
        endcase
    end

    // Debounce on complete frames; eval runs while row 0 of the next scan dwells.
    always_comb begin
        stable_d = stable_q;
        prev_d   = prev_q;
        frame_d  = frame_q;
        valid_d  = 1'b0;
        if (eval_q) begin
            if (raw_q == prev_q) begin
                if (stable_q == STABLE_MAX) begin
                    stable_d = STABLE_MAX;
                end else begin
                    stable_d = stable_q + SW'(1);
                end
            end else begin
                stable_d = '0;
            end
            prev_d = raw_q;
            // A stable frame equal to what is already shown is not re-announced.
            if ((stable_d == STABLE_MAX) && (raw_q != frame_q)) begin
                frame_d = raw_q;
                valid_d = 1'b1;
            end else begin
                frame_d = frame_q;
            end
        end else begin
            prev_d = prev_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge PIXEL_CLK or posedge reset) begin
        if (reset) begin
            col_meta_q <= 5'b00000;
            col_sync_q <= 5'b00000;
            dwell_q    <= '0;
            row_q      <= 3'd0;
            row_sel_q  <= 5'b00001;
            raw_q      <= 25'd0;
            prev_q     <= 25'd0;
            stable_q   <= '0;
            eval_q     <= 1'b0;
            frame_q    <= 25'd0;
            valid_q    <= 1'b0;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
            dwell_q    <= dwell_d;
            row_q      <= row_d;
            row_sel_q  <= row_sel_d;
            raw_q      <= raw_d;
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            eval_q     <= eval_d;
            frame_q    <= frame_d;
            valid_q    <= valid_d;
        end
    end

    assign row_sel     = row_sel_q;
    assign row0        = frame_q[4:0];
    assign row1        = frame_q[9:5];
    assign row2        = frame_q[14:10];
    assign row3        = frame_q[19:15];
    assign row4        = frame_q[24:20];
    assign frame_valid = valid_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// Bench for matrix_scanner: directed scenarios plus random key activity,
// checked every cycle against a scan-level reference model.
module tb_matrix_scanner;

    localparam int S = 8;
    localparam int D = 3;
    localparam int SCAN = 5 * S;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] col_in;
    logic [4:0] row_sel;
    logic [4:0] row0, row1, row2, row3, row4;
    logic       frame_valid;

    logic [24:0] pressed = 25'd0;

    int checks = 0;
    int failures = 0;

    // Model state
    int          t;
    logic [24:0] hist[$];
    logic [24:0] m_raw, m_prev, m_rows;
    int          m_stable;
    logic        exp_fv;
    int          pulse_cnt;
    int          last_pulse;

    matrix_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
        .PIXEL_CLK  (clk),
        .reset      (reset),
        .col_in     (col_in),
        .row_sel    (row_sel),
        .row0       (row0),
        .row1       (row1),
        .row2       (row2),
        .row3       (row3),
        .row4       (row4),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    // The physical matrix: a driven row exposes its pressed keys on the columns.
    always_comb begin
        col_in = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            if (row_sel[i]) col_in = col_in | pressed[5*i +: 5];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        t = 0;
        hist.delete();
        m_raw = 25'd0;
        m_prev = 25'd0;
        m_rows = 25'd0;
        m_stable = 0;
        exp_fv = 1'b0;
        pulse_cnt = 0;
        last_pulse = -1;
    endtask

    // One clock: record the key state, advance, then compare against the model.
    task automatic tick();
        logic [24:0] old_keys;
        int r;
        hist.push_back(pressed);
        if (hist.size() > 3) void'(hist.pop_front());
        @(posedge clk);
        #1;
        t++;
        exp_fv = 1'b0;
        if (t % S == 0) begin
            r = (t / S - 1) % 5;
            old_keys = hist[0];
            m_raw[5*r +: 5] = old_keys[5*r +: 5];
        end
        if ((t % SCAN == 1) && (t > 1)) begin
            if (m_raw == m_prev) m_stable = (m_stable + 1 > D - 1) ? D - 1 : m_stable + 1;
            else m_stable = 0;
            m_prev = m_raw;
            if ((m_stable == D - 1) && (m_raw != m_rows)) begin
                m_rows = m_raw;
                exp_fv = 1'b1;
            end
        end
        check("row_sel", 32'(row_sel), 32'(5'b00001 << ((t / S) % 5)));
        check("rows", 32'({row4, row3, row2, row1, row0}), 32'(m_rows));
        check("frame_valid", 32'(frame_valid), 32'(exp_fv));
        if (frame_valid === 1'b1) begin
            pulse_cnt++;
            last_pulse = t;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_row_sel"}, 32'(row_sel), 32'(5'b00001));
        check({tag, "_rows"}, 32'({row4, row3, row2, row1, row0}), 32'd0);
        check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("rst");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        int t0;
        model_clear();
        // Power-up reset, all keys open, then two idle scans with no pulse
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (81) tick();
        check("idle_pulses", 32'(pulse_cnt), 32'd0);

        // Static pattern held from reset release commits after scan 3
        pressed = {5'b00000, 5'b00100, 5'b10001, 5'b00000, 5'b11111};
        apply_reset();
        repeat (121) tick();
        check("pat_commit_t", 32'(last_pulse), 32'd121);
        check("pat_pulses", 32'(pulse_cnt), 32'd1);
        check("pat_row0", 32'(row0), 32'h1F);
        check("pat_row2", 32'(row2), 32'h11);
        check("pat_row3", 32'(row3), 32'h04);
        repeat (5 * SCAN) tick();
        check("pat_no_repeat", 32'(pulse_cnt), 32'd1);

        // Bounce switch (2,0) on alternate scans
        for (int k = 0; k < 6; k++) begin
            pressed[10] = (k % 2 == 1);
            repeat (SCAN) tick();
        end
        repeat (2 * SCAN) tick();
        check("bounce_row2", 32'(row2), 32'h11);
        check("bounce_pulses", 32'(pulse_cnt), 32'd1);

        // Release switch (3,2): one pulse three scans later
        pressed[17] = 1'b0;
        t0 = t;
        repeat (3 * SCAN) tick();
        check("release_t", 32'(last_pulse), 32'(t0 + 3 * SCAN));
        check("release_row3", 32'(row3), 32'h00);
        check("release_pulses", 32'(pulse_cnt), 32'd2);

        // Asynchronous reset at row 3, dwell 5
        while (t % SCAN != 29) tick();
        #1;
        reset = 1'b1;
        #1;
        check_reset_state("midscan");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (121) tick();
        check("recommit_t", 32'(last_pulse), 32'd121);
        check("recommit_row0", 32'(row0), 32'h1F);

        // Column change one cycle before row 1's sample edge is not seen that scan
        while (t % SCAN != 14) tick();
        t0 = t - 14;
        pressed[5] = 1'b1;
        while (t < t0 + 4 * SCAN + 1) tick();
        check("sync_latency_t", 32'(last_pulse), 32'(t0 + 4 * SCAN + 1));
        check("sync_row1", 32'(row1), 32'h01);

        // Random key activity with random hold lengths
        for (int seg = 0; seg < 10; seg++) begin
            pressed = 25'($urandom);
            repeat ($urandom_range(1, 4) * SCAN + $urandom_range(0, SCAN - 1)) tick();
        end
        repeat (4 * SCAN) tick();
        check("random_final", 32'({row4, row3, row2, row1, row0}), 32'(pressed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
